// File: rtl/sum_ser_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sum_ser_arbiter
//   Round-robin arbiter that shares one 3x9-bit sum/serializer datapath among
//   N_REQ packet sources. The winner's packet is captured and the datapath is
//   launched with a 1-cycle start pulse. The arbiter follows the datapath's
//   ready/busy handshake and returns a 1-cycle done pulse to the granted
//   source. After each transaction it waits GAP_CYC idle cycles before it
//   grants again.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined   : a watchdog counts cycles in WAIT_BUSY/WAIT_DONE. On reaching
//               TIMEOUT_CYC it ends the transaction with a done pulse and sets
//               err_o, which stays set until reset.
//   Undefined : the arbiter waits on the datapath indefinitely and err_o is 0.
//
// Ports
//   clk_i       in   system clock, rising edge
//   rst_ni      in   synchronous active-low reset
//   req_i       in   [N_REQ]         level request per source
//   data_i      in   [N_REQ*DATA_W]  packet per source, slice k = [k*DATA_W +: DATA_W]
//   gnt_o       out  [N_REQ]         one-hot grant, held for the whole transaction
//   done_o      out  [N_REQ]         1-cycle completion pulse to the granted source
//   dp_start_o  out  1-cycle launch pulse to the datapath
//   dp_data_o   out  [DATA_W]        registered packet to the datapath
//   dp_ready_i  in   datapath idle (1) / serializing (0)
//   busy_o      out  high in every state except IDLE
//   err_o       out  sticky timeout flag
// -----------------------------------------------------------------------------
module sum_ser_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 27,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        done_o,
  output logic                    dp_start_o,
  output logic [DATA_W-1:0]       dp_data_o,
  input  logic                    dp_ready_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       r_win;
  logic [N_REQ-1:0]    r_gnt;
  logic [N_REQ-1:0]    r_done;
  logic                r_start;
  logic [DATA_W-1:0]   r_data;
  logic                r_busy;
  logic                r_err;
  logic [GW-1:0]       r_gap_cnt;

  logic [DATA_W-1:0]   w_slices [N_REQ];
  logic [IW-1:0]       w_winner;
  logic                w_found;
  logic [N_REQ-1:0]    w_onehot;
  logic [IW-1:0]       w_ptr_next;

  // Unpack the flat data bus into one word per source.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_slices[gi] = data_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Winner = first requesting source at or after rr_ptr, wrapping past N_REQ-1.
  always_comb begin
    logic [IW:0] idx;
    w_winner = '0;
    w_found  = 1'b0;
    idx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, r_rr_ptr} + (IW+1)'(i);
      if (idx >= (IW+1)'(N_REQ)) begin
        idx = idx - (IW+1)'(N_REQ);
      end
      if (!w_found && req_i[idx[IW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = idx[IW-1:0];
      end
    end
  end

  assign w_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
  assign w_ptr_next = (r_win == IW'(N_REQ-1)) ? '0 : r_win + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to_cnt;
  logic          w_to_hit;
  logic          w_waiting;

  assign w_waiting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
  // The counter is cleared on entry to WAIT_BUSY, so this fires on the
  // TIMEOUT_CYC-th edge after the LAUNCH cycle.
  assign w_to_hit  = w_waiting && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !w_waiting) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_win     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_start   <= 1'b0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_LAUNCH;
            r_win   <= w_winner;
            r_gnt   <= w_onehot;
            r_data  <= w_slices[w_winner];
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_LAUNCH: begin
          r_start  <= 1'b0;
          r_rr_ptr <= w_ptr_next;
          r_state  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!dp_ready_i) begin
            r_state <= S_WAIT_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          if (w_to_hit) begin
            r_err   <= 1'b1;
            r_done  <= r_gnt;
            r_state <= S_DONE;
          end
`endif
        end
        S_WAIT_DONE: begin
          if (dp_ready_i) begin
            r_done  <= r_gnt;
            r_state <= S_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          if (w_to_hit) begin
            r_err   <= 1'b1;
            r_done  <= r_gnt;
            r_state <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          // done_o was shown alongside the grant for this cycle; drop both.
          r_done    <= '0;
          r_gnt     <= '0;
          r_gap_cnt <= '0;
          if (GAP_CYC > 0) begin
            r_state <= S_GAP;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GW'(GAP_CYC - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o      = r_gnt;
  assign done_o     = r_done;
  assign dp_start_o = r_start;
  assign dp_data_o  = r_data;
  assign busy_o     = r_busy;
  assign err_o      = r_err;

endmodule
